// File: rtl/eth_ipv4_udp_tx.sv
// Ethernet II + IPv4 + UDP transmit packetiser.
// Serialises one frame per accepted request onto a byte-wide valid/ready
// stream towards the MAC, then pulses TXN_DONE.
// Ports:
//   aclk, areset                  clock, synchronous active-high reset
//   ACCELERATOR_IP/MAC_ADDRESS    local source addresses
//   RECIPIENT_IP/MAC_ADDRESS      destination addresses
//   RECIPIENT_MESSAGE             payload, MSB byte first
//   START_IP_TXN / READY_FOR_SEND request / idle indication
//   TXN_DONE                      one-cycle pulse after the final byte handshake
//   MAC_DATA_*                    byte stream with FIRST/LAST framing
module eth_ipv4_udp_tx #(
  parameter int unsigned PAYLOAD_BYTES   = 2,
  parameter int unsigned MIN_FRAME_BYTES = 60,
  parameter int unsigned IP_TTL          = 64,
  parameter logic [15:0] UDP_SRC_PORT    = 16'h1F90,
  parameter logic [15:0] UDP_DST_PORT    = 16'h1F90
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic [31:0]                ACCELERATOR_IP_ADDRESS,
  input  logic [47:0]                ACCELERATOR_MAC_ADDRESS,
  input  logic [31:0]                RECIPIENT_IP_ADDRESS,
  input  logic [47:0]                RECIPIENT_MAC_ADDRESS,
  input  logic [8*PAYLOAD_BYTES-1:0] RECIPIENT_MESSAGE,
  input  logic                       START_IP_TXN,
  output logic                       READY_FOR_SEND,
  output logic                       TXN_DONE,
  output logic [7:0]                 MAC_DATA_OUT,
  output logic                       MAC_DATA_VALID,
  input  logic                       MAC_DATA_READY,
  output logic                       MAC_DATA_FIRST,
  output logic                       MAC_DATA_LAST
);

  localparam int unsigned MSG_W     = 8 * PAYLOAD_BYTES;
  localparam int unsigned HDR_BYTES = 42;
  localparam int unsigned PAD_BYTES = (MIN_FRAME_BYTES > HDR_BYTES + PAYLOAD_BYTES) ?
                                      (MIN_FRAME_BYTES - HDR_BYTES - PAYLOAD_BYTES) : 0;
  localparam bit          HAS_PAD   = (PAD_BYTES != 0);

  localparam logic [15:0] IP_TOTAL_LEN = 16'(28 + PAYLOAD_BYTES);
  localparam logic [15:0] UDP_LEN      = 16'(8 + PAYLOAD_BYTES);
  localparam logic [7:0]  TTL_BYTE     = 8'(IP_TTL);
  localparam logic [7:0]  LAST_PAY     = 8'(PAYLOAD_BYTES - 1);
  localparam logic [7:0]  LAST_PAD     = HAS_PAD ? 8'(PAD_BYTES - 1) : 8'd0;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CSUM = 3'd1;
  localparam logic [2:0] S_ETH  = 3'd2;
  localparam logic [2:0] S_IP   = 3'd3;
  localparam logic [2:0] S_UDP  = 3'd4;
  localparam logic [2:0] S_PAY  = 3'd5;
  localparam logic [2:0] S_PAD  = 3'd6;

  logic [2:0]       state, state_d;
  logic [7:0]       cnt, cnt_d;
  logic [19:0]      sum, sum_d;
  logic [15:0]      ident;
  logic [47:0]      dst_mac, src_mac;
  logic [31:0]      src_ip, dst_ip;
  logic [MSG_W-1:0] msg;

  logic [7:0]       data, data_d;
  logic             valid, valid_d;
  logic             first, first_d;
  logic             last, last_d;
  logic             done, done_d;
  logic             rfs;

  logic             capture;
  logic             ident_inc;
  logic             load_byte;
  logic             hs;
  logic [15:0]      csum_word;
  logic [16:0]      fold1, fold2;
  logic [15:0]      csum_c;
  logic [111:0]     eth_v;
  logic [159:0]     ip_v;
  logic [63:0]      udp_v;
  logic [MSG_W-1:0] msg_v;
  logic [7:0]       byte_c;

  // IPv4 header word fed to the checksum accumulator on each CSUM cycle
  always_comb begin
    csum_word = 16'h0000;
    case (cnt[3:0])
      4'd0:    csum_word = 16'h4500;
      4'd1:    csum_word = IP_TOTAL_LEN;
      4'd2:    csum_word = ident;
      4'd3:    csum_word = 16'h4000;
      4'd4:    csum_word = {TTL_BYTE, 8'h11};
      4'd6:    csum_word = src_ip[31:16];
      4'd7:    csum_word = src_ip[15:0];
      4'd8:    csum_word = dst_ip[31:16];
      4'd9:    csum_word = dst_ip[15:0];
      default: csum_word = 16'h0000;
    endcase
  end

  // Two end-around-carry folds of the 20-bit sum, then ones-complement
  always_comb begin
    fold1  = 17'(sum[15:0]) + 17'(sum[19:16]);
    fold2  = 17'(fold1[15:0]) + 17'(fold1[16]);
    csum_c = ~fold2[15:0];
  end

  // Next-state, byte counter and registered-output next values
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    sum_d     = sum;
    data_d    = data;
    valid_d   = valid;
    first_d   = first;
    last_d    = last;
    done_d    = 1'b0;
    capture   = 1'b0;
    ident_inc = 1'b0;
    load_byte = 1'b0;
    hs        = valid & MAC_DATA_READY;

    case (state)
      S_IDLE: begin
        if (START_IP_TXN) begin
          capture = 1'b1;
          state_d = S_CSUM;
          cnt_d   = 8'd0;
          sum_d   = 20'd0;
        end
      end
      S_CSUM: begin
        sum_d = sum + 20'(csum_word);
        cnt_d = cnt + 8'd1;
        if (cnt == 8'd9) begin
          state_d   = S_ETH;
          cnt_d     = 8'd0;
          load_byte = 1'b1;
        end
      end
      S_ETH: begin
        if (hs) begin
          load_byte = 1'b1;
          if (cnt == 8'd13) begin
            state_d = S_IP;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt + 8'd1;
          end
        end
      end
      S_IP: begin
        if (hs) begin
          load_byte = 1'b1;
          if (cnt == 8'd19) begin
            state_d = S_UDP;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt + 8'd1;
          end
        end
      end
      S_UDP: begin
        if (hs) begin
          load_byte = 1'b1;
          if (cnt == 8'd7) begin
            state_d = S_PAY;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt + 8'd1;
          end
        end
      end
      S_PAY: begin
        if (hs) begin
          if (cnt != LAST_PAY) begin
            cnt_d     = cnt + 8'd1;
            load_byte = 1'b1;
          end else if (HAS_PAD) begin
            state_d   = S_PAD;
            cnt_d     = 8'd0;
            load_byte = 1'b1;
          end else begin
            state_d   = S_IDLE;
            done_d    = 1'b1;
            ident_inc = 1'b1;
          end
        end
      end
      S_PAD: begin
        if (hs) begin
          if (cnt != LAST_PAD) begin
            cnt_d     = cnt + 8'd1;
            load_byte = 1'b1;
          end else begin
            state_d   = S_IDLE;
            done_d    = 1'b1;
            ident_inc = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Section images shifted so the byte at cnt_d sits in the top lane
    eth_v = {dst_mac, src_mac, 16'h0800} << {cnt_d, 3'b000};
    ip_v  = {8'h45, 8'h00, IP_TOTAL_LEN, ident, 16'h4000, TTL_BYTE, 8'h11,
             csum_c, src_ip, dst_ip} << {cnt_d, 3'b000};
    udp_v = {UDP_SRC_PORT, UDP_DST_PORT, UDP_LEN, 16'h0000} << {cnt_d, 3'b000};
    msg_v = msg << {cnt_d, 3'b000};

    case (state_d)
      S_ETH:   byte_c = eth_v[111:104];
      S_IP:    byte_c = ip_v[159:152];
      S_UDP:   byte_c = udp_v[63:56];
      S_PAY:   byte_c = msg_v[MSG_W-1 -: 8];
      default: byte_c = 8'h00;
    endcase

    if (load_byte) begin
      valid_d = 1'b1;
      data_d  = byte_c;
      first_d = (state_d == S_ETH) && (cnt_d == 8'd0);
      last_d  = ((state_d == S_PAY) && !HAS_PAD && (cnt_d == LAST_PAY)) ||
                ((state_d == S_PAD) && (cnt_d == LAST_PAD));
    end else if (state_d == S_IDLE) begin
      valid_d = 1'b0;
      data_d  = 8'h00;
      first_d = 1'b0;
      last_d  = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge aclk) begin
    if (areset) begin
      state <= S_IDLE;
      cnt   <= 8'd0;
      sum   <= 20'd0;
      data  <= 8'h00;
      valid <= 1'b0;
      first <= 1'b0;
      last  <= 1'b0;
      done  <= 1'b0;
      rfs   <= 1'b1;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      sum   <= sum_d;
      data  <= data_d;
      valid <= valid_d;
      first <= first_d;
      last  <= last_d;
      done  <= done_d;
      rfs   <= (state_d == S_IDLE);
    end
  end

  // Identification counter, wraps naturally at 16 bits
  always_ff @(posedge aclk) begin
    if (areset) begin
      ident <= 16'h0000;
    end else if (ident_inc) begin
      ident <= ident + 16'd1;
    end
  end

  // Request fields held for the whole frame
  always_ff @(posedge aclk) begin
    if (capture) begin
      dst_mac <= RECIPIENT_MAC_ADDRESS;
      src_mac <= ACCELERATOR_MAC_ADDRESS;
      src_ip  <= ACCELERATOR_IP_ADDRESS;
      dst_ip  <= RECIPIENT_IP_ADDRESS;
      msg     <= RECIPIENT_MESSAGE;
    end
  end

  assign READY_FOR_SEND = rfs;
  assign TXN_DONE       = done;
  assign MAC_DATA_OUT   = data;
  assign MAC_DATA_VALID = valid;
  assign MAC_DATA_FIRST = first;
  assign MAC_DATA_LAST  = last;

endmodule

// File: tb/tb_eth_ipv4_udp_tx.sv
// Directed bench for eth_ipv4_udp_tx: a default 2-byte-payload instance
// (padded frames, stall, back-to-back, mid-frame reset, ident wrap) and an
// 87-byte-payload instance (unpadded frame, checksum 0xB861).
module tb_eth_ipv4_udp_tx;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic        areset;
  logic [47:0] mac_loc, mac_rem;

  // default instance
  logic [31:0] ip_loc_a, ip_rem_a;
  logic [15:0] msg_a;
  logic        start_a, ready_a, rfs_a, done_a, valid_a, first_a, last_a;
  logic [7:0]  data_a;

  // 87-byte instance
  logic [31:0]  ip_loc_b, ip_rem_b;
  logic [695:0] msg_b;
  logic         start_b, ready_b, rfs_b, done_b, valid_b, first_b, last_b;
  logic [7:0]   data_b;

  eth_ipv4_udp_tx dut_a (
    .aclk(aclk), .areset(areset),
    .ACCELERATOR_IP_ADDRESS(ip_loc_a), .ACCELERATOR_MAC_ADDRESS(mac_loc),
    .RECIPIENT_IP_ADDRESS(ip_rem_a), .RECIPIENT_MAC_ADDRESS(mac_rem),
    .RECIPIENT_MESSAGE(msg_a), .START_IP_TXN(start_a),
    .READY_FOR_SEND(rfs_a), .TXN_DONE(done_a),
    .MAC_DATA_OUT(data_a), .MAC_DATA_VALID(valid_a), .MAC_DATA_READY(ready_a),
    .MAC_DATA_FIRST(first_a), .MAC_DATA_LAST(last_a)
  );

  eth_ipv4_udp_tx #(.PAYLOAD_BYTES(87)) dut_b (
    .aclk(aclk), .areset(areset),
    .ACCELERATOR_IP_ADDRESS(ip_loc_b), .ACCELERATOR_MAC_ADDRESS(mac_loc),
    .RECIPIENT_IP_ADDRESS(ip_rem_b), .RECIPIENT_MAC_ADDRESS(mac_rem),
    .RECIPIENT_MESSAGE(msg_b), .START_IP_TXN(start_b),
    .READY_FOR_SEND(rfs_b), .TXN_DONE(done_b),
    .MAC_DATA_OUT(data_b), .MAC_DATA_VALID(valid_b), .MAC_DATA_READY(ready_b),
    .MAC_DATA_FIRST(first_b), .MAC_DATA_LAST(last_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] frame [0:199];
  int nbytes, first_pos, last_pos, nfirst, nlast, lat, done_gap;
  int stall_ok, rfs_bad, abort_bad;
  bit fin;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Sends one frame on the default instance, recording bytes and framing.
  task automatic run_a(input int stall_len, input bit mid_start, input bit abort);
    int stalls;
    int last_cyc;
    nbytes = 0; first_pos = -1; last_pos = -1; nfirst = 0; nlast = 0;
    lat = -1; done_gap = -1; stall_ok = 0; rfs_bad = 0; abort_bad = 0;
    fin = 1'b0; stalls = 0; last_cyc = -1000;
    @(negedge aclk); start_a = 1'b1; ready_a = 1'b1;
    @(negedge aclk); start_a = 1'b0;
    for (int cyc = 1; cyc < 400 && !fin; cyc++) begin
      if (cyc > 1) @(negedge aclk);
      if (done_a) begin
        done_gap = cyc - last_cyc;
        fin = 1'b1;
      end else if (rfs_a !== 1'b0) begin
        rfs_bad++;
      end
      if (valid_a && lat < 0) lat = cyc;
      if (valid_a && !ready_a && nbytes == 16 && data_a === 8'h00) stall_ok++;
      if (valid_a && ready_a) begin
        frame[nbytes] = data_a;
        if (first_a) begin nfirst++; first_pos = nbytes; end
        if (last_a) begin nlast++; last_pos = nbytes; last_cyc = cyc; end
        nbytes++;
      end
      if (mid_start) begin
        start_a = (cyc == 30);
        if (cyc == 30) msg_a = 16'h1234;
      end
      if (nbytes == 16 && stalls < stall_len) begin
        ready_a = 1'b0;
        stalls++;
      end else begin
        ready_a = 1'b1;
      end
      if (abort && nbytes == 43 && !fin) begin
        areset = 1'b1;
        @(negedge aclk); areset = 1'b0;
        check("abort_valid", 32'(valid_a), 32'd0);
        check("abort_rfs", 32'(rfs_a), 32'd1);
        check("abort_done", 32'(done_a), 32'd0);
        repeat (80) begin
          @(negedge aclk);
          if (valid_a || last_a || done_a || !rfs_a) abort_bad++;
        end
        fin = 1'b1;
      end
    end
    start_a = 1'b0;
    ready_a = 1'b1;
    msg_a   = 16'hABCD;
    check("frame_terminated", 32'(fin), 32'd1);
  endtask

  // Compares a captured default-instance frame against its hand-built image.
  task automatic check_frame_a(input string tag, input logic [15:0] id, input logic [15:0] cs);
    logic [479:0] ev;
    ev = {48'h020000000002, 48'h020000000001, 16'h0800,
          16'h4500, 16'h001E, id, 16'h4000, 16'h4011, cs, 32'h0A000001, 32'h0A000002,
          16'h1F90, 16'h1F90, 16'h000A, 16'h0000,
          16'hABCD, 128'h0};
    check({tag, "_len"}, 32'(nbytes), 32'd60);
    check({tag, "_first"}, 32'(first_pos), 32'd0);
    check({tag, "_nfirst"}, 32'(nfirst), 32'd1);
    check({tag, "_last"}, 32'(last_pos), 32'd59);
    check({tag, "_nlast"}, 32'(nlast), 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'd11);
    check({tag, "_done_gap"}, 32'(done_gap), 32'd1);
    check({tag, "_rfs_busy"}, 32'(rfs_bad), 32'd0);
    for (int i = 0; i < 60; i++)
      check($sformatf("%s_byte%0d", tag, i), 32'(frame[i]), 32'(ev[479 - 8*i -: 8]));
  endtask

  initial begin
    int idle_bad;
    int bfirst, blast, bn, bdone;
    logic [95:0] iph;
    areset   = 1'b1;
    mac_loc  = 48'h020000000001;
    mac_rem  = 48'h020000000002;
    ip_loc_a = 32'h0A000001;
    ip_rem_a = 32'h0A000002;
    msg_a    = 16'hABCD;
    start_a  = 1'b0;
    ready_a  = 1'b1;
    ip_loc_b = 32'hC0A80001;
    ip_rem_b = 32'hC0A800C7;
    for (int i = 0; i < 87; i++) msg_b[8*(86-i) +: 8] = 8'(i + 1);
    start_b  = 1'b0;
    ready_b  = 1'b1;

    repeat (2) @(negedge aclk);
    areset = 1'b0;
    check("rst_valid", 32'(valid_a), 32'd0);
    check("rst_first", 32'(first_a), 32'd0);
    check("rst_last", 32'(last_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_data", 32'(data_a), 32'd0);
    check("rst_rfs", 32'(rfs_a), 32'd1);
    check("rst_rfs_b", 32'(rfs_b), 32'd1);
    check("rst_valid_b", 32'(valid_b), 32'd0);

    // Frame 1: id 0, START pulse and message change while busy
    run_a(0, 1'b1, 1'b0);
    check_frame_a("f1", 16'h0000, 16'h26CD);
    idle_bad = 0;
    repeat (6) begin
      @(negedge aclk);
      if (valid_a || !rfs_a) idle_bad++;
    end
    check("f1_start_dropped", 32'(idle_bad), 32'd0);

    // Frame 2: back-to-back, id 1, five-cycle stall on IP header byte 3
    run_a(5, 1'b0, 1'b0);
    check_frame_a("f2", 16'h0001, 16'h26CC);
    check("f2_stall_hold", 32'(stall_ok), 32'd5);

    // Frame 3: reset during payload
    run_a(0, 1'b0, 1'b1);
    check("f3_abort_quiet", 32'(abort_bad), 32'd0);
    check("f3_nlast", 32'(nlast), 32'd0);

    // Frame 4: ident restarted by reset
    run_a(0, 1'b0, 1'b0);
    check_frame_a("f4", 16'h0000, 16'h26CD);

    // Identification wrap via backdoor
    @(negedge aclk);
    force dut_a.ident = 16'hFFFF;
    @(negedge aclk);
    release dut_a.ident;
    run_a(0, 1'b0, 1'b0);
    check_frame_a("f5", 16'hFFFF, 16'h26CD);
    run_a(0, 1'b0, 1'b0);
    check_frame_a("f6", 16'h0000, 16'h26CD);

    // 87-byte payload instance: 129-byte frame, no padding
    bn = 0; bfirst = -1; blast = -1; bdone = 0;
    @(negedge aclk); start_b = 1'b1;
    @(negedge aclk); start_b = 1'b0;
    for (int cyc = 1; cyc < 400 && bdone == 0; cyc++) begin
      if (cyc > 1) @(negedge aclk);
      if (done_b) bdone = 1;
      if (valid_b && ready_b) begin
        frame[bn] = data_b;
        if (first_b) bfirst = bn;
        if (last_b) blast = bn;
        bn++;
      end
    end
    check("b_done", 32'(bdone), 32'd1);
    check("b_len", 32'(bn), 32'd129);
    check("b_first", 32'(bfirst), 32'd0);
    check("b_last", 32'(blast), 32'd128);
    iph = 96'h4500_0073_0000_4000_4011_B861;
    for (int i = 0; i < 12; i++)
      check($sformatf("b_iphdr%0d", i), 32'(frame[14 + i]), 32'(iph[95 - 8*i -: 8]));
    check("b_udp_len_hi", 32'(frame[38]), 32'h00);
    check("b_udp_len_lo", 32'(frame[39]), 32'h5F);
    for (int i = 0; i < 87; i++)
      check($sformatf("b_pay%0d", i), 32'(frame[42 + i]), 32'(i + 1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
